// File: rtl/cdb_pkg.sv
// Shared types for the common-data-bus write-back arbiter: result entry, tag defaults, round-robin step.
package cdb_pkg;

    localparam int TAG_W_DEF  = 3;
    localparam int DATA_W_DEF = 32;

    localparam logic [TAG_W_DEF-1:0] NO_TAG = '0;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] value;
    } cdb_entry_t;

    // Next round-robin index after a grant to idx, among n candidates.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-requester result FIFO: write visible at head one edge after push; full/empty from registered count,
// so a same-cycle pop never frees space for a same-cycle push. Flush empties it on the next edge.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  cdb_entry_t i_entry,
    input  logic       i_pop,
    output cdb_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    cdb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (i_push && !i_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (i_pop && !i_push) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin write-back arbiter onto a registered CDB; 1-cycle push-to-broadcast, req_ready = FIFO not full.
// Define CDB_MEM_PRIO_EN to give requester N_REQ-1 (memory) absolute priority over the round-robin group.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int N_REQ  = 3,
    parameter  int TAG_W  = TAG_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 2,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_value,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_num,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [SRC_W-1:0]          cdb_src
);

    logic [N_REQ-1:0]  w_push;
    logic [N_REQ-1:0]  w_pop;
    logic [N_REQ-1:0]  w_full;
    logic [N_REQ-1:0]  w_empty;
    cdb_entry_t        w_head [N_REQ];

    logic              w_gnt_vld;
    logic [SRC_W-1:0]  w_gnt_idx;
    logic [SRC_W-1:0]  w_cand;

    logic [SRC_W-1:0]  r_rr;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_num;
    logic [DATA_W-1:0] r_cdb_value;
    logic [SRC_W-1:0]  r_cdb_src;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        cdb_entry_t w_in;
        assign w_in = {req_tag[gi*TAG_W +: TAG_W], req_value[gi*DATA_W +: DATA_W]};
        // Tag 0 is handshaken but never stored.
        assign w_push[gi]    = req_valid[gi] && !w_full[gi] && !flush && (w_in.tag != NO_TAG);
        assign w_pop[gi]     = w_gnt_vld && (w_gnt_idx == SRC_W'(gi));
        assign req_ready[gi] = !w_full[gi];

        cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush),
            .i_push  (w_push[gi]),
            .i_entry (w_in),
            .i_pop   (w_pop[gi]),
            .o_head  (w_head[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi])
        );
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
`ifdef CDB_MEM_PRIO_EN
        if (!w_empty[N_REQ-1]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SRC_W'(N_REQ - 1);
        end else begin
            for (int k = 0; k < N_REQ - 1; k++) begin
                w_cand = SRC_W'((int'(r_rr) + k) % (N_REQ - 1));
                if (!w_gnt_vld && !w_empty[w_cand]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = SRC_W'((int'(r_rr) + k) % N_REQ);
            if (!w_gnt_vld && !w_empty[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
`endif
        // Flush discards the candidate: no pop, no broadcast, no pointer move.
        if (flush) w_gnt_vld = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr        <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_num   <= '0;
            r_cdb_value <= '0;
            r_cdb_src   <= '0;
        end else if (w_gnt_vld) begin
            r_cdb_valid <= 1'b1;
            r_cdb_num   <= w_head[w_gnt_idx].tag;
            r_cdb_value <= w_head[w_gnt_idx].value;
            r_cdb_src   <= w_gnt_idx;
`ifdef CDB_MEM_PRIO_EN
            if (w_gnt_idx != SRC_W'(N_REQ - 1)) begin
                r_rr <= SRC_W'(rr_next(int'(w_gnt_idx), N_REQ - 1));
            end
`else
            r_rr <= SRC_W'(rr_next(int'(w_gnt_idx), N_REQ));
`endif
        end else begin
            r_cdb_valid <= 1'b0;
            r_cdb_num   <= '0;
            r_cdb_value <= '0;
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_num   = r_cdb_num;
    assign cdb_value = r_cdb_value;
    assign cdb_src   = r_cdb_src;

endmodule
